apb_master_mux: RTL
===================

Name: apb_master_mux

Overview:
- Parametrised APB master with a registered command/response front end and an address-decoded select for NUM_SLAVES slaves.
- Drives compliant SETUP/ACCESS phases, wait states via PREADY, PSTRB byte strobes and PSLVERR error return.
- Supports back-to-back transfers without an IDLE gap.
- Sits between the system-side request logic and the APB peripheral bus.

Parameters:
- ADDR_W, 32, width of cmd_addr/PADDR
- DATA_W, 32, width of data buses; must be 8, 16 or 32
- NUM_SLAVES, 4, number of PSEL lines (1..16)
- SEL_W, $clog2(NUM_SLAVES) (minimum 1), decode field width taken from PADDR[ADDR_W-1 -: SEL_W]
- TIMEOUT_CYCLES, 256, ACCESS-phase cycle limit (used only with the optional feature)

Ports:
- PCLK  in  1  clock, all logic on rising edge
- PRESET  in  1  asynchronous, active-high reset
- cmd_valid  in  1  request present
- cmd_ready  out  1  request accepted when cmd_valid && cmd_ready
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  byte address
- cmd_wdata  in  DATA_W  write data
- cmd_strb  in  DATA_W/8  write byte strobes
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  DATA_W  read data; 0 for writes and errors
- rsp_err  out  1  PSLVERR, decode error or timeout
- PSEL  out  NUM_SLAVES  one-hot slave select
- PENABLE  out  1  ACCESS phase
- PWRITE  out  1  transfer direction
- PADDR  out  ADDR_W  transfer address
- PWDATA  out  DATA_W  write data
- PSTRB  out  DATA_W/8  byte strobes; forced to 0 on reads
- PRDATA  in  DATA_W  read data from the selected slave
- PREADY  in  1  slave ready
- PSLVERR  in  1  slave error, sampled only with PREADY

Behaviour:
- Reset values: all outputs 0; state IDLE. Reset takes effect mid-transfer: bus is released immediately and no response is issued for the dropped transfer.
- All APB outputs and rsp_* are registered. cmd_ready is combinational: 1 in IDLE, and in ACCESS when PREADY=1; otherwise 0.
- IDLE: on accept, capture addr/wdata/strb/write into PADDR/PWDATA/PSTRB/PWRITE and decode index = cmd_addr[ADDR_W-1 -: SEL_W].
  - index < NUM_SLAVES -> SETUP.
  - index >= NUM_SLAVES -> no PSEL asserted; next cycle rsp_valid=1, rsp_err=1, rsp_rdata=0; stay IDLE.
- SETUP (one cycle): PSEL[index]=1, PENABLE=0 -> ACCESS.
- ACCESS: PENABLE=1; PADDR/PWDATA/PSTRB/PWRITE/PSEL held stable.
  - PREADY=0: wait.
  - PREADY=1: next cycle rsp_valid=1, rsp_err=PSLVERR, rsp_rdata = PRDATA on a read with no error, else 0.
  - Then, if a new command is accepted in the same cycle and it decodes valid -> SETUP with the new command (PENABLE=0, PSEL updated). Otherwise PSEL=0, PENABLE=0 -> IDLE.
  - A back-to-back command that decodes invalid -> IDLE with its decode-error response one cycle after the previous response.
- Latency: accept at cycle N; SETUP at N+1; ACCESS at N+2; response pulse at the cycle after PREADY is sampled high (N+3 with zero wait states).
- rsp_valid is never held; the consumer must always accept it.
- PSTRB = 0 for reads regardless of cmd_strb.

Optional Feature:
- Macro APB_MASTER_TIMEOUT_EN.
- Defined: a counter clears on entry to ACCESS and increments each ACCESS cycle with PREADY=0. On reaching TIMEOUT_CYCLES, PSEL and PENABLE drop next cycle, the response is rsp_err=1 and rsp_rdata=0, and the state returns to IDLE.
- Not defined: no counter; ACCESS waits for PREADY indefinitely.

Test Plan:
- Write addr 0x0000_0010, wdata 0xDEAD_BEEF, strb 0xF, PREADY tied 1 -> PSEL=0001 for two cycles, PENABLE high in the second; rsp_valid at N+3 with rsp_err=0, rsp_rdata=0.
- Read addr 0x4000_0004 with 3 wait states, PRDATA=0x1234_5678 -> PSEL=0010; PENABLE high for 4 cycles; rsp_rdata=0x1234_5678; PSTRB=0 throughout.
- Back-to-back write then read with cmd_valid held -> second SETUP immediately follows first ACCESS; no IDLE cycle; two rsp pulses 2 cycles apart.
- NUM_SLAVES=3, addr 0xC000_0000 -> no PSEL bit asserted; rsp_err=1 one cycle after accept.
- PSLVERR=1 with PREADY=1 on a read, PRDATA=0xFFFF_FFFF -> rsp_err=1, rsp_rdata=0.
- PRESET asserted during an ACCESS wait state -> PSEL, PENABLE and rsp_valid are 0 immediately. With APB_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=8, PREADY held 0 -> rsp_err=1 after 8 ACCESS cycles.

Source files
------------

// File: rtl/apb_master_mux.sv
// APB master with registered command/response front end and address-decoded PSEL.
// Optional ACCESS-phase timeout enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master_mux #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int NUM_SLAVES     = 4,
  parameter int SEL_W          = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [DATA_W-1:0]     cmd_wdata,
  input  logic [DATA_W/8-1:0]   cmd_strb,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic [NUM_SLAVES-1:0] PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_W-1:0]     PADDR,
  output logic [DATA_W-1:0]     PWDATA,
  output logic [DATA_W/8-1:0]   PSTRB,
  input  logic [DATA_W-1:0]     PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  if (!(DATA_W == 8 || DATA_W == 16 || DATA_W == 32)) begin : g_bad_data_w
    $error("apb_master_mux: DATA_W must be 8, 16 or 32");
  end
  if (NUM_SLAVES < 1 || NUM_SLAVES > 16 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("apb_master_mux: NUM_SLAVES must be 1..16 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t                state, state_n;
  logic [SEL_W-1:0]      dec_idx;
  logic                  dec_ok;
  logic [NUM_SLAVES-1:0] dec_sel;
  logic                  accept;
  logic                  pend, pend_n;
  logic [NUM_SLAVES-1:0] psel_n;
  logic                  penable_n, pwrite_n;
  logic [ADDR_W-1:0]     paddr_n;
  logic [DATA_W-1:0]     pwdata_n, rsp_rdata_n;
  logic [DATA_W/8-1:0]   pstrb_n;
  logic                  rsp_valid_n, rsp_err_n;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tcnt, tcnt_n;
`endif

  assign dec_idx   = cmd_addr[ADDR_W-1 -: SEL_W];
  assign dec_ok    = 32'(dec_idx) < 32'(NUM_SLAVES);
  assign dec_sel   = NUM_SLAVES'(1) << dec_idx;
  assign cmd_ready = !PRESET && ((state == IDLE) || (state == ACCESS && PREADY));
  assign accept    = cmd_valid && cmd_ready;

  always_comb begin
    state_n     = state;
    psel_n      = PSEL;
    penable_n   = PENABLE;
    pwrite_n    = PWRITE;
    paddr_n     = PADDR;
    pwdata_n    = PWDATA;
    pstrb_n     = PSTRB;
    rsp_valid_n = 1'b0;
    rsp_err_n   = 1'b0;
    rsp_rdata_n = '0;
    pend_n      = 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
    tcnt_n      = tcnt;
`endif
    case (state)
      IDLE: begin
        if (pend) begin
          rsp_valid_n = 1'b1;
          rsp_err_n   = 1'b1;
        end
      end
      SETUP: begin
        penable_n = 1'b1;
        state_n   = ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
        tcnt_n    = '0;
`endif
      end
      ACCESS: begin
        if (PREADY) begin
          rsp_valid_n = 1'b1;
          rsp_err_n   = PSLVERR;
          rsp_rdata_n = (!PWRITE && !PSLVERR) ? PRDATA : '0;
          psel_n      = '0;
          penable_n   = 1'b0;
          state_n     = IDLE;
        end
`ifdef APB_MASTER_TIMEOUT_EN
        else if (tcnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          rsp_valid_n = 1'b1;
          rsp_err_n   = 1'b1;
          psel_n      = '0;
          penable_n   = 1'b0;
          state_n     = IDLE;
        end else begin
          tcnt_n = tcnt + CNT_W'(1);
        end
`endif
      end
      default: state_n = IDLE;
    endcase

    // A decode error that collides with another response is deferred one cycle
    if (accept) begin
      pwrite_n  = cmd_write;
      paddr_n   = cmd_addr;
      pwdata_n  = cmd_wdata;
      pstrb_n   = cmd_write ? cmd_strb : '0;
      penable_n = 1'b0;
      if (dec_ok) begin
        psel_n  = dec_sel;
        state_n = SETUP;
      end else begin
        psel_n  = '0;
        state_n = IDLE;
        if (rsp_valid_n) begin
          pend_n = 1'b1;
        end else begin
          rsp_valid_n = 1'b1;
          rsp_err_n   = 1'b1;
          rsp_rdata_n = '0;
        end
      end
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state     <= IDLE;
      pend      <= 1'b0;
      PSEL      <= '0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      PSTRB     <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state     <= state_n;
      pend      <= pend_n;
      PSEL      <= psel_n;
      PENABLE   <= penable_n;
      PWRITE    <= pwrite_n;
      PADDR     <= paddr_n;
      PWDATA    <= pwdata_n;
      PSTRB     <= pstrb_n;
      rsp_valid <= rsp_valid_n;
      rsp_err   <= rsp_err_n;
      rsp_rdata <= rsp_rdata_n;
    end
  end

`ifdef APB_MASTER_TIMEOUT_EN
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) tcnt <= '0;
    else        tcnt <= tcnt_n;
  end
`endif

endmodule
